pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//   Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   Drives each register's write enable and bubble/flush, and generates EX-stage operand forwarding selects.
//   Handles multi-cycle data-memory freezes, load-use stalls and taken-branch flushes.
//   Keeps a saturating stall-cycle counter for performance readout.
// PARAMETERS
//   RG_W      4   register address width (matches Rg fields in pipeline registers)
//   MEM_WAIT  2   extra cycles a data-memory access holds the pipe frozen (0 = single-cycle memory)
//   CNT_W     16  width of stall_cycles counter
// PORTS
//   clk          in   1      pipeline clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   id_rs_a      in   RG_W   ID-stage source A register
//   id_rs_b      in   RG_W   ID-stage source B register
//   id_use_a     in   1      ID instruction reads source A
//   id_use_b     in   1      ID instruction reads source B
//   ex_rs_a      in   RG_W   EX-stage source A (forwarding compare)
//   ex_rs_b      in   RG_W   EX-stage source B
//   ex_rg        in   RG_W   EX-stage destination register
//   ex_we        in   1      EX instruction writes ex_rg
//   ex_is_load   in   1      EX instruction is a load
//   br_taken     in   1      branch resolved taken in EX
//   mem_rg       in   RG_W   MEM-stage destination
//   mem_we       in   1      MEM instruction writes mem_rg
//   mem_req      in   1      MEM stage holds a load/store this cycle
//   wb_rg        in   RG_W   WB-stage destination
//   wb_we        in   1      WB instruction writes wb_rg
//   we_pc, we_if_id, we_id_ex, we_ex_mem, we_mem_wb  out 1  register latch enables (1 = capture)
//   flush_if_id  out  1      load NOP into IF/ID on capture
//   flush_id_ex  out  1      load NOP (all WE/SEL controls 0) into ID/EX on capture
//   fwd_a, fwd_b out  2      00 = regfile, 01 = EX/MEM ALU_Result, 10 = MEM/WB writeback data
//   stall_cycles out  CNT_W  count of cycles with we_pc = 0, saturates at all-ones
// BEHAVIOUR
//   - Reset (rst_n = 0, async): state RUN, wait counter 0, stall_cycles 0. All we_* = 0, both flush = 1, fwd = 00.
//   - States: RUN, MEM_STALL. A 2-bit-or-wider wait counter is used in MEM_STALL.
//   - RUN, mem_req = 1 and MEM_WAIT > 0: all we_* = 0, flush = 0.
//       - Next state MEM_STALL with counter = MEM_WAIT-1. mem_req has highest priority.
//   - MEM_STALL, counter > 0: all we_* = 0, counter decrements.
//   - MEM_STALL, counter = 0 (release cycle): next state RUN.
//       - Outputs evaluated as in RUN, but mem_req is ignored.
//       - Frozen cycles per access = MEM_WAIT exactly.
//   - RUN/release, br_taken = 1: all we_* = 1, flush_if_id = 1, flush_id_ex = 1.
//       - Branch beats load-use (the ID instruction is on the wrong path).
//   - RUN/release, load-use: ex_is_load & ex_we & ((id_use_a & id_rs_a == ex_rg) | (id_use_b & id_rs_b == ex_rg)).
//       - Response: we_pc = we_if_id = 0, we_id_ex = 1 with flush_id_ex = 1, we_ex_mem = we_mem_wb = 1.
//       - Exactly one bubble; the retry resolves via MEM/WB forwarding.
//   - Otherwise all we_* = 1, flush = 0.
//   - Forwarding (combinational, every state):
//       - fwd_a = 01 if mem_we & mem_rg == ex_rs_a.
//       - Else fwd_a = 10 if wb_we & wb_rg == ex_rs_a.
//       - Else fwd_a = 00. fwd_b is computed the same way with ex_rs_b.
//       - EX/MEM beats MEM/WB. Register 0 is not special.
//   - stall_cycles increments on every rising edge where we_pc = 0 (reset excluded) and holds at 2^CNT_W-1.
//   - rst_n asserted mid-MEM_STALL aborts the wait immediately. Release from reset resumes in RUN.
//   - Control outputs depend on state and inputs only. They are valid before the next rising edge; there are no glitch requirements.
// STRUCTURE
//   - pipe_ctrl_pkg holds:
//       - state enum {RUN, MEM_STALL}
//       - FWD_RF = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10
//   - Sub-module fwd_unit: pure combinational forwarding compare, instantiated once per operand.
//   - FSM, wait counter and stall counter stay in the top module.
// TESTING
//   1 Reset low for 3 cycles, then release -> cycle 1: all we_* = 1, flush = 0, fwd = 00, stall_cycles = 0.
//   2 mem_req = 1 for one access, MEM_WAIT = 2 -> we_* = 0 for exactly 2 cycles.
//       Third cycle: all we_* = 1. stall_cycles = 2.
//   3 ex_is_load = 1, ex_we = 1, ex_rg = 5, id_use_b = 1, id_rs_b = 5 -> one cycle: we_pc = 0, flush_id_ex = 1.
//       Next cycle: normal operation (ex_is_load = 0).
//   4 br_taken = 1 together with a load-use hit -> flush_if_id = flush_id_ex = 1, we_pc = 1, stall_cycles unchanged.
//   5 mem_we = 1, mem_rg = 3; wb_we = 1, wb_rg = 3; ex_rs_a = 3, ex_rs_b = 7 -> fwd_a = 01, fwd_b = 00.
//       Then set mem_we = 0 -> fwd_a = 10.
//   6 rst_n pulsed low during MEM_STALL (counter = 1) -> outputs go to reset values immediately.
//       After release: RUN, and mem_req = 0 gives all we_* = 1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM states, forwarding-select codes and the bundle of register write enables.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN       = 1'b0,
    MEM_STALL = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } we_t;

  localparam we_t WE_ALL  = '{pc: 1'b1, if_id: 1'b1, id_ex: 1'b1, ex_mem: 1'b1, mem_wb: 1'b1};
  localparam we_t WE_NONE = '{pc: 1'b0, if_id: 1'b0, id_ex: 1'b0, ex_mem: 1'b0, mem_wb: 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EX-stage operand forwarding compare for one source operand.
// The younger EX/MEM result takes precedence over MEM/WB; register 0 is an ordinary register.
module fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int RG_W = 4
) (
  input  logic [RG_W-1:0] ex_rs,
  input  logic [RG_W-1:0] mem_rg,
  input  logic            mem_we,
  input  logic [RG_W-1:0] wb_rg,
  input  logic            wb_we,
  output logic [1:0]      sel
);

  // NOTE: a default assignment first keeps every path assigned, so no latch is inferred.
  always_comb begin
    sel = FWD_RF;
    if (mem_we && (mem_rg == ex_rs)) begin
      sel = FWD_EXMEM;
    end else if (wb_we && (wb_rg == ex_rs)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register sequencer: memory freezes, load-use bubbles, branch flushes,
// operand forwarding selects and a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RG_W     = 4,
  parameter int MEM_WAIT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RG_W-1:0]  id_rs_a,
  input  logic [RG_W-1:0]  id_rs_b,
  input  logic             id_use_a,
  input  logic             id_use_b,
  input  logic [RG_W-1:0]  ex_rs_a,
  input  logic [RG_W-1:0]  ex_rs_b,
  input  logic [RG_W-1:0]  ex_rg,
  input  logic             ex_we,
  input  logic             ex_is_load,
  input  logic             br_taken,
  input  logic [RG_W-1:0]  mem_rg,
  input  logic             mem_we,
  input  logic             mem_req,
  input  logic [RG_W-1:0]  wb_rg,
  input  logic             wb_we,
  output logic             we_pc,
  output logic             we_if_id,
  output logic             we_id_ex,
  output logic             we_ex_mem,
  output logic             we_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WAIT_W = (MEM_WAIT < 4) ? 2 : $clog2(MEM_WAIT + 1);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  we_t               we;
  logic              resolve;
  logic              load_use;
  logic [1:0]        fwd_a_raw, fwd_b_raw;

  assign load_use = ex_is_load && ex_we &&
                    ((id_use_a && (id_rs_a == ex_rg)) || (id_use_b && (id_rs_b == ex_rg)));

  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    we          = WE_ALL;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    resolve     = 1'b0;

    unique case (state)
      RUN: begin
        if (mem_req && (MEM_WAIT > 0)) begin
          we        = WE_NONE;
          state_nxt = MEM_STALL;
          wait_nxt  = WAIT_W'(MEM_WAIT - 1);
        end else begin
          resolve = 1'b1;
        end
      end
      MEM_STALL: begin
        if (wait_cnt != '0) begin
          we       = WE_NONE;
          wait_nxt = wait_cnt - 1'b1;
        end else begin
          // Release cycle: the access is complete, so mem_req is not re-examined.
          state_nxt = RUN;
          resolve   = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase

    if (resolve) begin
      if (br_taken) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (load_use) begin
        we.pc       = 1'b0;
        we.if_id    = 1'b0;
        flush_id_ex = 1'b1;
      end
    end

    if (!rst_n) begin
      we          = WE_NONE;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end
  end

  assign we_pc     = we.pc;
  assign we_if_id  = we.if_id;
  assign we_id_ex  = we.id_ex;
  assign we_ex_mem = we.ex_mem;
  assign we_mem_wb = we.mem_wb;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      wait_cnt     <= '0;
      stall_cycles <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (!we.pc && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

  fwd_unit #(.RG_W(RG_W)) u_fwd_a (
    .ex_rs (ex_rs_a),
    .mem_rg(mem_rg),
    .mem_we(mem_we),
    .wb_rg (wb_rg),
    .wb_we (wb_we),
    .sel   (fwd_a_raw)
  );

  fwd_unit #(.RG_W(RG_W)) u_fwd_b (
    .ex_rs (ex_rs_b),
    .mem_rg(mem_rg),
    .mem_we(mem_we),
    .wb_rg (wb_rg),
    .wb_we (wb_we),
    .sel   (fwd_b_raw)
  );

  assign fwd_a = rst_n ? fwd_a_raw : FWD_RF;
  assign fwd_b = rst_n ? fwd_b_raw : FWD_RF;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a randomized run,
// all compared against a cycle-level reference model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int RG_W     = 4;
  localparam int MEM_WAIT = 2;
  localparam int CNT_W    = 16;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [RG_W-1:0]  id_rs_a, id_rs_b, ex_rs_a, ex_rs_b, ex_rg, mem_rg, wb_rg;
  logic             id_use_a, id_use_b, ex_we, ex_is_load, br_taken;
  logic             mem_we, mem_req, wb_we;
  logic             we_pc, we_if_id, we_id_ex, we_ex_mem, we_mem_wb;
  logic             flush_if_id, flush_id_ex;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: frozen cycles still owed, whether this cycle is a release, stall count.
  int m_frozen  = 0;
  bit m_release = 0;
  int m_stall   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.RG_W(RG_W), .MEM_WAIT(MEM_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs_a(id_rs_a), .id_rs_b(id_rs_b), .id_use_a(id_use_a), .id_use_b(id_use_b),
    .ex_rs_a(ex_rs_a), .ex_rs_b(ex_rs_b), .ex_rg(ex_rg), .ex_we(ex_we),
    .ex_is_load(ex_is_load), .br_taken(br_taken),
    .mem_rg(mem_rg), .mem_we(mem_we), .mem_req(mem_req),
    .wb_rg(wb_rg), .wb_we(wb_we),
    .we_pc(we_pc), .we_if_id(we_if_id), .we_id_ex(we_id_ex),
    .we_ex_mem(we_ex_mem), .we_mem_wb(we_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cycles(stall_cycles)
  );

  function automatic logic [1:0] model_fwd(input logic [RG_W-1:0] rs);
    if (mem_we && mem_rg == rs) return 2'b01;
    if (wb_we && wb_rg == rs)   return 2'b10;
    return 2'b00;
  endfunction

  task automatic clear_inputs();
    {id_rs_a, id_rs_b, ex_rs_a, ex_rs_b, ex_rg, mem_rg, wb_rg} = '0;
    {id_use_a, id_use_b, ex_we, ex_is_load, br_taken, mem_we, mem_req, wb_we} = '0;
  endtask

  task automatic model_reset();
    m_frozen  = 0;
    m_release = 0;
    m_stall   = 0;
  endtask

  // Compare combinational outputs mid-cycle, advance the model at the edge, then check the counter.
  task automatic tick(input string name);
    logic [4:0] exp_we;
    logic       exp_fif, exp_fide, lu;
    bit         frz;
    @(negedge clk);
    frz = (m_frozen > 0) || (!m_release && mem_req && MEM_WAIT > 0);
    lu  = ex_is_load && ex_we &&
          ((id_use_a && id_rs_a == ex_rg) || (id_use_b && id_rs_b == ex_rg));
    if (frz)           begin exp_we = 5'b00000; exp_fif = 0; exp_fide = 0; end
    else if (br_taken) begin exp_we = 5'b11111; exp_fif = 1; exp_fide = 1; end
    else if (lu)       begin exp_we = 5'b00111; exp_fif = 0; exp_fide = 1; end
    else               begin exp_we = 5'b11111; exp_fif = 0; exp_fide = 0; end

    n_tests++;
    if ({we_pc, we_if_id, we_id_ex, we_ex_mem, we_mem_wb} !== exp_we) begin
      n_fail++;
      $display("FAIL %s we: got %b expected %b", name,
               {we_pc, we_if_id, we_id_ex, we_ex_mem, we_mem_wb}, exp_we);
    end
    n_tests++;
    if ({flush_if_id, flush_id_ex} !== {exp_fif, exp_fide}) begin
      n_fail++;
      $display("FAIL %s flush: got %b expected %b", name,
               {flush_if_id, flush_id_ex}, {exp_fif, exp_fide});
    end
    n_tests++;
    if ({fwd_a, fwd_b} !== {model_fwd(ex_rs_a), model_fwd(ex_rs_b)}) begin
      n_fail++;
      $display("FAIL %s fwd: got a=%b b=%b expected a=%b b=%b", name, fwd_a, fwd_b,
               model_fwd(ex_rs_a), model_fwd(ex_rs_b));
    end

    @(posedge clk);
    if (m_frozen > 0) begin
      m_frozen--;
      m_release = (m_frozen == 0);
    end else if (frz) begin
      m_frozen  = MEM_WAIT - 1;
      m_release = (m_frozen == 0);
    end else begin
      m_release = 0;
    end
    if (!exp_we[4] && m_stall != CNT_MAX) m_stall++;
    #1;
    n_tests++;
    if (stall_cycles !== CNT_W'(m_stall)) begin
      n_fail++;
      $display("FAIL %s stall_cycles: got %0d expected %0d", name, stall_cycles, m_stall);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_tests++;
    if ({we_pc, we_if_id, we_id_ex, we_ex_mem, we_mem_wb, flush_if_id, flush_id_ex,
         fwd_a, fwd_b, stall_cycles} !== {5'b00000, 2'b11, 4'b0000, CNT_W'(0)}) begin
      n_fail++;
      $display("FAIL %s: got we=%b flush=%b fwd=%b/%b stall=%0d expected we=00000 flush=11 fwd=00/00 stall=0",
               name, {we_pc, we_if_id, we_id_ex, we_ex_mem, we_mem_wb},
               {flush_if_id, flush_id_ex}, fwd_a, fwd_b, stall_cycles);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    // Forwarding hits present during reset must still read as regfile.
    mem_we = 1'b1; mem_rg = 4'd3; ex_rs_a = 4'd3; mem_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_hold");
    @(posedge clk); #1;
    clear_inputs();
    rst_n = 1'b1;
    model_reset();
    tick("post_reset");
  endtask

  task automatic test_mem_stall();
    int s0;
    s0 = m_stall;
    mem_req = 1'b1;
    tick("mem_freeze_1");
    mem_req = 1'b0;
    tick("mem_freeze_2");
    tick("mem_release");
    n_tests++;
    if (int'(stall_cycles) !== s0 + 2) begin
      n_fail++;
      $display("FAIL mem_stall_count: got %0d expected %0d", stall_cycles, s0 + 2);
    end
    // mem_req held through the release cycle is ignored there, then starts a new access.
    mem_req = 1'b1;
    repeat (3) tick("mem_held_req");
    tick("mem_second_access");
    mem_req = 1'b0;
    tick("mem_second_release");
  endtask

  task automatic test_load_use();
    ex_is_load = 1'b1; ex_we = 1'b1; ex_rg = 4'd5; id_use_b = 1'b1; id_rs_b = 4'd5;
    tick("load_use_bubble");
    ex_is_load = 1'b0;
    tick("load_use_retry");
    ex_is_load = 1'b1; id_use_b = 1'b0;
    tick("load_no_use");
    id_use_a = 1'b1; id_rs_a = 4'd5;
    tick("load_use_a");
    clear_inputs();
  endtask

  task automatic test_branch();
    int s0;
    ex_is_load = 1'b1; ex_we = 1'b1; ex_rg = 4'd5; id_use_b = 1'b1; id_rs_b = 4'd5;
    br_taken = 1'b1;
    s0 = m_stall;
    tick("branch_over_load_use");
    n_tests++;
    if (int'(stall_cycles) !== s0) begin
      n_fail++;
      $display("FAIL branch_stall_unchanged: got %0d expected %0d", stall_cycles, s0);
    end
    clear_inputs();
  endtask

  task automatic test_forwarding();
    mem_we = 1'b1; mem_rg = 4'd3; wb_we = 1'b1; wb_rg = 4'd3;
    ex_rs_a = 4'd3; ex_rs_b = 4'd7;
    tick("fwd_exmem_priority");
    mem_we = 1'b0;
    tick("fwd_memwb");
    ex_rs_a = 4'd0; ex_rs_b = 4'd0; mem_we = 1'b1; mem_rg = 4'd0; wb_rg = 4'd0;
    tick("fwd_reg0");
    clear_inputs();
  endtask

  task automatic test_reset_mid_stall();
    mem_req = 1'b1;
    tick("pre_abort_freeze");
    rst_n = 1'b0;
    mem_req = 1'b0;
    #1;
    check_reset_outputs("abort_immediate");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick("abort_resume_run");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      id_rs_a    = RG_W'($urandom_range(0, 3));
      id_rs_b    = RG_W'($urandom_range(0, 3));
      ex_rs_a    = RG_W'($urandom_range(0, 3));
      ex_rs_b    = RG_W'($urandom_range(0, 3));
      ex_rg      = RG_W'($urandom_range(0, 3));
      mem_rg     = RG_W'($urandom_range(0, 3));
      wb_rg      = RG_W'($urandom_range(0, 3));
      id_use_a   = 1'($urandom);
      id_use_b   = 1'($urandom);
      ex_we      = 1'($urandom);
      ex_is_load = 1'($urandom);
      br_taken   = ($urandom_range(0, 7) == 0);
      mem_we     = 1'($urandom);
      wb_we      = 1'($urandom);
      mem_req    = ($urandom_range(0, 5) == 0);
      tick("random");
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_mem_stall();
    test_load_use();
    test_branch();
    test_forwarding();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
